// File: rtl/vtx_mem_mp.sv
// Multi-port vertex/data memory: NPORTS synchronous ports on one shared array, per-lane write
// masks, lowest-port-wins lane arbitration on same-address writes, and a built-in clear sequencer.
module vtx_mem_mp #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned NPORTS = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr,
  output logic                               busy,
  input  logic [NPORTS-1:0]                  req,
  input  logic [NPORTS-1:0]                  we,
  input  logic [NPORTS*LANES-1:0]            lane_en,
  input  logic [NPORTS*ADDR_W-1:0]           addr,
  input  logic [NPORTS*LANES*LANE_W-1:0]     wdata,
  output logic [NPORTS*LANES*LANE_W-1:0]     rdata,
  output logic [NPORTS-1:0]                  rvalid,
  output logic                               wcoll
);

  localparam int unsigned DW    = LANES * LANE_W;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e                   state_q;
  logic [ADDR_W-1:0]        cnt_q;
  logic                     wcoll_q;
  logic [NPORTS-1:0]        rvalid_q;
  logic [NPORTS*DW-1:0]     rdata_q;
  logic [DW-1:0]            mem_q [DEPTH];

  logic                     idle;
  logic [NPORTS-1:0]        wr;
  logic [ADDR_W-1:0]        a     [NPORTS];
  logic [DW-1:0]            own_w [NPORTS];
  logic [DW-1:0]            mrg_w [NPORTS];
  logic                     coll;

  assign idle = (state_q == StIdle);

  for (genvar g = 0; g < int'(NPORTS); g++) begin : g_port
    assign a[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wr[g] = idle & req[g] & we[g];
  end

  // own_w: the port's own masked write only (write-first readback).
  // mrg_w: all writes to that address merged, lower port index applied last so it wins.
  always_comb begin
    coll = 1'b0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      own_w[p] = mem_q[a[p]];
      mrg_w[p] = mem_q[a[p]];
      for (int l = 0; l < int'(LANES); l++) begin
        if (wr[p] && lane_en[p*LANES+l]) begin
          own_w[p][l*LANE_W +: LANE_W] = wdata[p*DW + l*LANE_W +: LANE_W];
        end
      end
      for (int q = int'(NPORTS) - 1; q >= 0; q--) begin
        for (int l = 0; l < int'(LANES); l++) begin
          if (wr[q] && (a[q] == a[p]) && lane_en[q*LANES+l]) begin
            mrg_w[p][l*LANE_W +: LANE_W] = wdata[q*DW + l*LANE_W +: LANE_W];
          end
        end
      end
      for (int q = p + 1; q < int'(NPORTS); q++) begin
        if (wr[p] && wr[q] && (a[p] == a[q])) coll = 1'b1;
      end
    end
  end

  // Colliding ports all store the same merged word, so overlapping writes agree.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        if (wr[p]) mem_q[a[p]] <= mrg_w[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StClear;
      cnt_q    <= '0;
      wcoll_q  <= 1'b0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) state_q <= StIdle;
        end
        StIdle: begin
          if (clr) begin
            state_q <= StClear;
            cnt_q   <= '0;
            wcoll_q <= 1'b0;
          end else if (coll) begin
            wcoll_q <= 1'b1;
          end
        end
      endcase
      rvalid_q <= idle ? req : '0;
      for (int p = 0; p < int'(NPORTS); p++) begin
        if (idle && req[p]) rdata_q[p*DW +: DW] <= own_w[p];
      end
    end
  end

  assign busy   = (state_q == StClear);
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign wcoll  = wcoll_q;

endmodule

// File: tb/tb_vtx_mem_mp.sv
// Directed self-checking bench for vtx_mem_mp at default parameters (2 ports, 4x32-bit lanes).
module tb_vtx_mem_mp;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         busy;
  logic [1:0]   req, we;
  logic [7:0]   lane_en;
  logic [15:0]  addr;
  logic [255:0] wdata;
  logic [255:0] rdata;
  logic [1:0]   rvalid;
  logic         wcoll;

  int n_vec  = 0;
  int n_miss = 0;

  vtx_mem_mp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .busy    (busy),
    .req     (req),
    .we      (we),
    .lane_en (lane_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .wcoll   (wcoll)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [3:0] m,
                          input logic [7:0] ad, input logic [127:0] d);
    req[p]             = r;
    we[p]              = w;
    lane_en[p*4 +: 4]  = m;
    addr[p*8 +: 8]     = ad;
    wdata[p*128 +: 128] = d;
  endtask

  task automatic idle_ports();
    set_port(0, 1'b0, 1'b0, 4'h0, 8'h00, '0);
    set_port(1, 1'b0, 1'b0, 4'h0, 8'h00, '0);
  endtask

  function automatic logic [127:0] rd(input int p);
    return rdata[p*128 +: 128];
  endfunction

  // Counts edges until busy drops, bounded so a stuck sequencer still reaches the summary.
  task automatic busy_len(input string tag, input logic hold_req);
    int   n  = 0;
    logic rv = 1'b0;
    while (busy && n < 1000) begin
      if (hold_req) begin
        set_port(0, 1'b1, 1'b1, 4'hf, 8'h40, {4{32'hffffffff}});
        set_port(1, 1'b1, 1'b0, 4'h0, 8'h40, '0);
      end
      tick();
      rv |= |rvalid;
      n++;
    end
    idle_ports();
    check_eq(tag, 128'(n), 128'd256);
    if (hold_req) check_eq({tag, "_rvalid"}, 128'(rv), 128'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    idle_ports();
    #12;
    check_eq("rst_busy", 128'(busy), 128'd1);
    check_eq("rst_rvalid", 128'(rvalid), 128'd0);
    check_eq("rst_rdata", rd(0), '0);
    check_eq("rst_wcoll", 128'(wcoll), 128'd0);
    rst_n = 1'b1;
    busy_len("clear_len", 1'b0);
    check_eq("idle_rvalid", 128'(rvalid), 128'd0);

    for (int i = 0; i < 256; i++) begin
      set_port(0, 1'b1, 1'b0, 4'h0, 8'(i), '0);
      tick();
      check_eq("clr_rvalid", 128'(rvalid), 128'd1);
      check_eq("clr_rdata", rd(0), '0);
    end
    idle_ports();
    tick();
    check_eq("rvalid_drop", 128'(rvalid), 128'd0);

    // Masked write, write-first readback on the writing port
    set_port(0, 1'b1, 1'b1, 4'hf, 8'h10, {4{32'haaaaaaaa}});
    tick();
    check_eq("wr_full", rd(0), {4{32'haaaaaaaa}});
    set_port(0, 1'b1, 1'b1, 4'b0101, 8'h10, 128'h11111111_22222222_33333333_44444444);
    tick();
    check_eq("wr_mask_same", rd(0), 128'haaaaaaaa_22222222_aaaaaaaa_44444444);
    set_port(0, 1'b1, 1'b0, 4'hf, 8'h10, '0);
    tick();
    check_eq("wr_mask_read", rd(0), 128'haaaaaaaa_22222222_aaaaaaaa_44444444);
    set_port(0, 1'b1, 1'b1, 4'h0, 8'h10, '1);
    tick();
    check_eq("wr_nomask", rd(0), 128'haaaaaaaa_22222222_aaaaaaaa_44444444);
    check_eq("wr_nomask_rv", 128'(rvalid[0]), 128'd1);

    // Cross-port read sees the pre-cycle word
    set_port(0, 1'b1, 1'b1, 4'hf, 8'h05, {4{32'hdeadbeef}});
    set_port(1, 1'b1, 1'b0, 4'h0, 8'h05, '0);
    tick();
    check_eq("xport_old", rd(1), '0);
    check_eq("xport_wr", rd(0), {4{32'hdeadbeef}});
    check_eq("xport_rv", 128'(rvalid), 128'd3);
    set_port(0, 1'b0, 1'b0, 4'h0, 8'h00, '0);
    tick();
    check_eq("xport_new", rd(1), {4{32'hdeadbeef}});

    // Distinct addresses on both ports do not collide
    set_port(0, 1'b1, 1'b1, 4'hf, 8'h30, {4{32'h33333333}});
    set_port(1, 1'b1, 1'b1, 4'hf, 8'h31, {4{32'h44444444}});
    tick();
    check_eq("nocoll_wcoll", 128'(wcoll), 128'd0);
    set_port(0, 1'b1, 1'b0, 4'h0, 8'h31, '0);
    set_port(1, 1'b1, 1'b0, 4'h0, 8'h30, '0);
    tick();
    check_eq("dual_rd0", rd(0), {4{32'h44444444}});
    check_eq("dual_rd1", rd(1), {4{32'h33333333}});

    // Same-address collision: lane 1 overlaps, port 0 wins it
    set_port(0, 1'b1, 1'b1, 4'b0011, 8'h20, {4{32'h00000001}});
    set_port(1, 1'b1, 1'b1, 4'b0110, 8'h20, {4{32'h00000002}});
    tick();
    check_eq("coll_own0", rd(0), 128'h00000000_00000000_00000001_00000001);
    check_eq("coll_own1", rd(1), 128'h00000000_00000002_00000002_00000000);
    check_eq("coll_wcoll", 128'(wcoll), 128'd1);
    set_port(0, 1'b1, 1'b0, 4'h0, 8'h20, '0);
    set_port(1, 1'b1, 1'b0, 4'h0, 8'h20, '0);
    tick();
    check_eq("coll_word0", rd(0), 128'h00000000_00000002_00000001_00000001);
    check_eq("coll_word1", rd(1), 128'h00000000_00000002_00000001_00000001);
    check_eq("coll_sticky", 128'(wcoll), 128'd1);
    idle_ports();

    // clr in idle: wcoll cleared, requests ignored while busy, array zeroed
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_busy", 128'(busy), 128'd1);
    check_eq("clr_wcoll", 128'(wcoll), 128'd0);
    busy_len("reclear_len", 1'b1);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] ads [5] = '{8'h05, 8'h10, 8'h20, 8'h30, 8'h40};
      set_port(0, 1'b1, 1'b0, 4'h0, ads[i], '0);
      tick();
      check_eq("reclear_zero", rd(0), '0);
    end

    // Reset mid-access with non-zero outputs
    set_port(0, 1'b1, 1'b1, 4'hf, 8'h50, {4{32'h12345678}});
    set_port(1, 1'b1, 1'b1, 4'hf, 8'h50, {4{32'h9abcdef0}});
    tick();
    check_eq("pre_rst_wcoll", 128'(wcoll), 128'd1);
    check_eq("pre_rst_rdata", rd(0), {4{32'h12345678}});
    rst_n = 1'b0;
    #1;
    idle_ports();
    check_eq("arst_busy", 128'(busy), 128'd1);
    check_eq("arst_rvalid", 128'(rvalid), 128'd0);
    check_eq("arst_rdata", rd(0), '0);
    check_eq("arst_wcoll", 128'(wcoll), 128'd0);
    tick();
    rst_n = 1'b1;
    busy_len("arst_clear_len", 1'b0);

    // Reset during a clear at address 100
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check_eq("mid_clear_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 128'(busy), 128'd1);
    check_eq("mid_rst_rvalid", 128'(rvalid), 128'd0);
    tick();
    rst_n = 1'b1;
    busy_len("mid_rst_len", 1'b0);
    set_port(0, 1'b1, 1'b0, 4'h0, 8'h50, '0);
    tick();
    check_eq("final_zero", rd(0), '0);
    idle_ports();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vtx_mem_mp.md
# vtx_mem_mp

Parametrised multi-port vertex/data memory for the GPU datapath, successor to the fixed two-port 128-bit store. It provides NPORTS independent synchronous read/write ports onto one shared array of LANES×LANE_W-bit words, with per-lane write masks and deterministic same-address write arbitration. A built-in clear sequencer zeroes the array after reset and on request. Instruction-side and vertex-fetch/rasteriser-side clients each own one port.

## Interface
- ADDR_W, 8, address width; depth = 2**ADDR_W words
- LANE_W, 32, bits per lane (one vertex component)
- LANES, 4, lanes per word; word width DW = LANES*LANE_W
- NPORTS, 2, number of ports (1..4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  start clear sequence (pulse; sampled when idle)
- busy  out  1  clear sequence running; all port requests ignored
- req  in  NPORTS  per-port access request
- we  in  NPORTS  per-port write (valid with req)
- lane_en  in  NPORTS*LANES  per-port lane write mask, port p at [p*LANES +: LANES]
- addr  in  NPORTS*ADDR_W  per-port address, packed likewise
- wdata  in  NPORTS*DW  per-port write data, packed likewise
- rdata  out  NPORTS*DW  per-port registered read data
- rvalid  out  NPORTS  per-port read data valid
- wcoll  out  1  sticky: two ports wrote the same address in one cycle; cleared by clr or reset

## Operation
- FSM states: CLEAR, IDLE. Reset → CLEAR. In CLEAR a counter walks 0..2**ADDR_W-1 writing all-zero words, one per cycle; after writing the last address → IDLE. In IDLE, clr=1 → CLEAR with counter=0, wcoll cleared.
- busy=1 exactly while in CLEAR. req is ignored in CLEAR: no write, rvalid=0.
- In IDLE, port p with req[p]=1 is serviced every cycle; there is no backpressure.
- Write (req&we): lanes with lane_en=1 take wdata lanes; other lanes keep stored value. lane_en=0 entirely → no change, but still returns a read.
- Own-port read is write-first: rdata[p] = stored word after merging port p's own masked write (not other ports' writes).
- Cross-port same-cycle same-address: a reading port sees the old word (pre-cycle contents).
- Write collision (≥2 ports write same address same cycle): per lane, the lowest-index port with that lane enabled wins; non-overlapping lanes from different ports all land. wcoll set to 1.
- Read (req&!we): rdata[p] = stored word.
- Out-of-range addresses are impossible (depth is a full power of two).

## Timing
- Reset values: busy=1, rvalid=0, rdata=0, wcoll=0, FSM=CLEAR, counter=0. Array contents undefined until clear completes.
- Clear lasts exactly 2**ADDR_W cycles; busy falls on the edge following the last clear write; first request accepted that cycle.
- Read latency 1: request on edge n → rdata/rvalid valid after edge n+1; rvalid[p] = registered req[p] (0 in CLEAR). rdata holds its last value when rvalid=0.
- Writes visible to all ports for requests at edge n+1 onward.
- clr during CLEAR is ignored (counter not restarted).
- rst_n low mid-clear or mid-access: immediate return to reset values; clear restarts from address 0 after release.
- Back-to-back accesses each cycle per port at full throughput.

## Test plan
- Reset release, defaults (ADDR_W=8): busy=1 for 256 cycles then 0; read all addresses on port 0 → rdata=0, rvalid 1 cycle after req.
- Masked write: port 0 writes addr 0x10 data 0xAAAA…(all lanes 0xAAAAAAAA) mask 1111, then 0x11111111_22222222_33333333_44444444 mask 0101 → read returns 0xAAAAAAAA_22222222_AAAAAAAA_44444444; same-cycle rdata of 2nd write equals that value.
- Cross-port: port 0 writes 0x5 = 0xDEAD… while port 1 reads 0x5 same cycle → port 1 sees old value; next-cycle read sees new.
- Collision: ports 0 and 1 write addr 0x20, port 0 mask 0011 data all 0x1, port 1 mask 0110 data all 0x2 → word lanes [3:0] = 0,2,1,1; wcoll=1 until clr.
- clr in IDLE after writes → busy 256 cycles, wcoll=0, all words read 0; request during busy → rvalid=0, no write.
- rst_n asserted at clear address 100 → outputs reset immediately; after release full 256-cycle clear again.
